ddr3_req_arbiter: RTL and testbench

//  Shares the single DDR3 controller request port between the AXI read path
//  (FETCH) and the AXI write path (STORE). Batches same-direction requests to

---
 rtl/ddr3_req_arbiter.sv | 130 +++++++++++++
 tb/tb_ddr3_req_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ddr3_req_arbiter.sv
// Arbitrates the single DDR3 controller request port between the AXI read (fetch) and write (store) paths.
// Define ARB_RAW_HAZARD_EN to force write-first when both pending requests hit the same burst granule.
module ddr3_req_arbiter #(
    parameter int ADDRS        = 32,
    parameter int AXI_ID_WIDTH = 4,
    parameter int MAX_RUN      = 4,
    parameter int HAZARD_LSB   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rd_fetch_i,
    output logic                    rd_accept_o,
    input  logic [AXI_ID_WIDTH-1:0] rd_reqid_i,
    input  logic [ADDRS-1:0]        rd_addr_i,
    input  logic                    wr_store_i,
    output logic                    wr_accept_o,
    input  logic [AXI_ID_WIDTH-1:0] wr_reqid_i,
    input  logic [ADDRS-1:0]        wr_addr_i,
    output logic                    ctl_req_o,
    input  logic                    ctl_accept_i,
    output logic                    ctl_write_o,
    output logic [AXI_ID_WIDTH-1:0] ctl_reqid_o,
    output logic [ADDRS-1:0]        ctl_addr_o
);

    localparam int CNT_W = $clog2(MAX_RUN + 1);
    localparam logic [CNT_W-1:0] MAX_RUN_C = CNT_W'(MAX_RUN);
`ifdef ARB_RAW_HAZARD_EN
    localparam bit HAZARD_EN = 1'b1;
`else
    localparam bit HAZARD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;

    state_t                  state_reg, state_next;
    logic                    last_dir_reg, last_dir_next;   // 1 = write
    logic [CNT_W-1:0]        run_cnt_reg, run_cnt_next;
    logic                    ctl_req_reg, ctl_req_next;
    logic                    ctl_write_reg, ctl_write_next;
    logic [AXI_ID_WIDTH-1:0] ctl_reqid_reg, ctl_reqid_next;
    logic [ADDRS-1:0]        ctl_addr_reg, ctl_addr_next;

    logic hazard;
    logic grant_write;
    logic handshake;

    assign handshake = ctl_req_reg & ctl_accept_i;

    // Winner selection; only consulted while idle with something pending.
    always_comb begin
        hazard = HAZARD_EN &&
                 (rd_addr_i[ADDRS-1:HAZARD_LSB] == wr_addr_i[ADDRS-1:HAZARD_LSB]);
        if (rd_fetch_i && wr_store_i) begin
            if (hazard)
                grant_write = 1'b1;
            else if (run_cnt_reg < MAX_RUN_C)
                grant_write = last_dir_reg;
            else
                grant_write = ~last_dir_reg;
        end else begin
            grant_write = wr_store_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            last_dir_reg  <= 1'b0;
            run_cnt_reg   <= '0;
            ctl_req_reg   <= 1'b0;
            ctl_write_reg <= 1'b0;
            ctl_reqid_reg <= '0;
            ctl_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            last_dir_reg  <= last_dir_next;
            run_cnt_reg   <= run_cnt_next;
            ctl_req_reg   <= ctl_req_next;
            ctl_write_reg <= ctl_write_next;
            ctl_reqid_reg <= ctl_reqid_next;
            ctl_addr_reg  <= ctl_addr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        last_dir_next  = last_dir_reg;
        run_cnt_next   = run_cnt_reg;
        ctl_req_next   = ctl_req_reg;
        ctl_write_next = ctl_write_reg;
        ctl_reqid_next = ctl_reqid_reg;
        ctl_addr_next  = ctl_addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rd_fetch_i || wr_store_i) begin
                    ctl_req_next   = 1'b1;
                    ctl_write_next = grant_write;
                    ctl_reqid_next = grant_write ? wr_reqid_i : rd_reqid_i;
                    ctl_addr_next  = grant_write ? wr_addr_i : rd_addr_i;
                    state_next     = grant_write ? ST_WR : ST_RD;
                    last_dir_next  = grant_write;
                    if (grant_write == last_dir_reg)
                        run_cnt_next = (run_cnt_reg == MAX_RUN_C) ? MAX_RUN_C
                                                                  : run_cnt_reg + 1'b1;
                    else
                        run_cnt_next = CNT_W'(1);
                end
            end
            ST_RD, ST_WR: begin
                if (handshake) begin
                    ctl_req_next = 1'b0;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_accept_o = handshake & ~ctl_write_reg;
        wr_accept_o = handshake & ctl_write_reg;
    end

    assign ctl_req_o   = ctl_req_reg;
    assign ctl_write_o = ctl_write_reg;
    assign ctl_reqid_o = ctl_reqid_reg;
    assign ctl_addr_o  = ctl_addr_reg;

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Directed plus randomized checks of ddr3_req_arbiter against a transaction-level arbitration model.
module tb_ddr3_req_arbiter;

    localparam int ADDRS   = 32;
    localparam int IDW     = 4;
    localparam int MAX_RUN = 4;
    localparam int HLSB    = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             rd_fetch_i = 1'b0;
    logic             rd_accept_o;
    logic [IDW-1:0]   rd_reqid_i = '0;
    logic [ADDRS-1:0] rd_addr_i = '0;
    logic             wr_store_i = 1'b0;
    logic             wr_accept_o;
    logic [IDW-1:0]   wr_reqid_i = '0;
    logic [ADDRS-1:0] wr_addr_i = '0;
    logic             ctl_req_o;
    logic             ctl_accept_i = 1'b0;
    logic             ctl_write_o;
    logic [IDW-1:0]   ctl_reqid_o;
    logic [ADDRS-1:0] ctl_addr_o;

    int passed = 0;
    int total  = 0;

    // Reference model state: direction of the previous grant and its run length.
    bit m_last_write;
    int m_run;

    ddr3_req_arbiter #(
        .ADDRS(ADDRS), .AXI_ID_WIDTH(IDW), .MAX_RUN(MAX_RUN), .HAZARD_LSB(HLSB)
    ) dut (
        .clock(clock), .reset(reset),
        .rd_fetch_i(rd_fetch_i), .rd_accept_o(rd_accept_o),
        .rd_reqid_i(rd_reqid_i), .rd_addr_i(rd_addr_i),
        .wr_store_i(wr_store_i), .wr_accept_o(wr_accept_o),
        .wr_reqid_i(wr_reqid_i), .wr_addr_i(wr_addr_i),
        .ctl_req_o(ctl_req_o), .ctl_accept_i(ctl_accept_i),
        .ctl_write_o(ctl_write_o), .ctl_reqid_o(ctl_reqid_o), .ctl_addr_o(ctl_addr_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_pick(input bit rd, input bit wr,
                                      input logic [ADDRS-1:0] rda, input logic [ADDRS-1:0] wra);
        bit same_granule;
        same_granule = ((rda >> HLSB) == (wra >> HLSB));
        if (!(rd && wr)) return wr;
`ifdef ARB_RAW_HAZARD_EN
        if (same_granule) return 1'b1;
`endif
        if (m_run < MAX_RUN) return m_last_write;
        return !m_last_write;
    endfunction

    task automatic model_grant(input bit w);
        if (w == m_last_write) m_run = (m_run >= MAX_RUN) ? MAX_RUN : m_run + 1;
        else m_run = 1;
        m_last_write = w;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rd_fetch_i = 1'b0; wr_store_i = 1'b0; ctl_accept_i = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        m_last_write = 1'b0;
        m_run = 0;
    endtask

    // One full request: present inputs while idle, wait `delay` refused cycles, then accept.
    task automatic do_req(input string tag, input bit rd, input bit wr,
                          input logic [ADDRS-1:0] rda, input logic [ADDRS-1:0] wra,
                          input logic [IDW-1:0] rid, input logic [IDW-1:0] wid,
                          input int delay, output bit dir);
        logic [ADDRS-1:0] ea;
        logic [IDW-1:0]   ei;
        rd_fetch_i = rd; wr_store_i = wr;
        rd_addr_i = rda; wr_addr_i = wra; rd_reqid_i = rid; wr_reqid_i = wid;
        dir = model_pick(rd, wr, rda, wra);
        model_grant(dir);
        ea = dir ? wra : rda;
        ei = dir ? wid : rid;
        @(posedge clock); #1;
        check({tag, "_req"}, 64'(ctl_req_o), 64'(1));
        check({tag, "_dir"}, 64'(ctl_write_o), 64'(dir));
        check({tag, "_addr"}, 64'(ctl_addr_o), 64'(ea));
        check({tag, "_id"}, 64'(ctl_reqid_o), 64'(ei));
        for (int i = 0; i < delay; i++) begin
            rd_addr_i = $urandom; wr_addr_i = $urandom;
            rd_reqid_i = IDW'($urandom); wr_reqid_i = IDW'($urandom);
            #1;
            check({tag, "_noacc"}, 64'({rd_accept_o, wr_accept_o}), 64'(0));
            @(posedge clock); #1;
            check({tag, "_hold"}, 64'({ctl_req_o, ctl_write_o, ctl_reqid_o, ctl_addr_o}),
                  64'({1'b1, dir, ei, ea}));
        end
        ctl_accept_i = 1'b1;
        #1;
        check({tag, "_acc"}, 64'({rd_accept_o, wr_accept_o}), 64'({!dir, dir}));
        @(posedge clock); #1;
        ctl_accept_i = 1'b0;
        rd_fetch_i = 1'b0; wr_store_i = 1'b0;
        check({tag, "_done"}, 64'({ctl_req_o, rd_accept_o, wr_accept_o}), 64'(0));
        $display("txn %s rd=%0b wr=%0b granted=%s addr=%08h id=%0h delay=%0d",
                 tag, rd, wr, dir ? "W" : "R", ea, ei, delay);
    endtask

    initial begin
        bit d;
        bit exp_pat [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        bit exp_hz;

        // Reset state
        do_reset();
        check("rst_outs", 64'({ctl_req_o, ctl_write_o, ctl_reqid_o, ctl_addr_o}), 64'(0));
        check("rst_acc", 64'({rd_accept_o, wr_accept_o}), 64'(0));

        // Single read
        do_req("t1", 1, 0, 32'h100, 32'h0, 4'd3, 4'd0, 0, d);
        check("t1_isread", 64'(d), 64'(0));

        // Both pending: run-length batching
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_req("t2", 1, 1, 32'h2000 + 32'(i * 64), 32'h8000 + 32'(i * 64),
                   4'd1, 4'd2, 0, d);
            check($sformatf("t2_order%0d", i), 64'(d), 64'(exp_pat[i]));
        end

        // Write held unaccepted for 10 cycles while inputs wander
        do_req("t3", 0, 1, 32'h0, 32'hABCD0, 4'd0, 4'd7, 10, d);

        // Async reset while a write awaits acceptance
        do_reset();
        do_req("t4a", 0, 1, 32'h0, 32'h300, 4'd0, 4'd5, 0, d);
        wr_store_i = 1'b1; wr_addr_i = 32'h340; wr_reqid_i = 4'd6;
        @(posedge clock); #1;
        check("t4_pending", 64'({ctl_req_o, ctl_write_o}), 64'(2'b11));
        #2;
        reset = 1'b1;
        ctl_accept_i = 1'b1;
        #1;
        check("t4_async", 64'({ctl_req_o, ctl_write_o, ctl_addr_o}), 64'(0));
        check("t4_noacc", 64'({rd_accept_o, wr_accept_o}), 64'(0));
        do_reset();
        do_req("t4b", 1, 1, 32'h500, 32'h900, 4'd1, 4'd2, 0, d);
        check("t4_read_after", 64'(d), 64'(0));

        // Read-after-write hazard in the same granule
        do_reset();
        do_req("t5a", 1, 0, 32'h40, 32'h0, 4'd1, 4'd0, 0, d);
`ifdef ARB_RAW_HAZARD_EN
        exp_hz = 1'b1;
`else
        exp_hz = 1'b0;
`endif
        do_req("t5b", 1, 1, 32'h1234, 32'h1238, 4'd3, 4'd4, 0, d);
        check("t5_first", 64'(d), 64'(exp_hz));

        // Write-only stream saturates the run counter; reads then win at once
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_req("t6w", 0, 1, 32'h0, 32'h10000 + 32'(i * 16), 4'd0, IDW'(i), 0, d);
            check("t6_wgrant", 64'(d), 64'(1));
        end
        do_req("t6b", 1, 1, 32'h700, 32'h900, 4'd8, 4'd9, 0, d);
        check("t6_read", 64'(d), 64'(0));

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            int pend;
            logic [ADDRS-1:0] ra, wa;
            pend = $urandom_range(1, 3);
            ra = $urandom;
            wa = ($urandom_range(0, 3) == 0) ? (ra ^ 32'(4'hC)) : $urandom;
            do_req($sformatf("rnd%0d", i), pend[0], pend[1], ra, wa,
                   IDW'($urandom), IDW'($urandom), $urandom_range(0, 3), d);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
